data_ram_resp: RTL and testbench
================================

Name: data_ram_resp

Overview:
- Data-memory responder that sits on the MEM-stage data bus of the multi-cycle CPU, on the far side of the dm_addr/dm_wen/dm_wdata/dm_rdata interface.
- Holds a word-organised RAM with per-byte-lane writes and synchronous reads. Read data is registered, so it appears one clock after the address; the MEM stage relies on this 1-cycle load latency.
- Also provides a registered display/debug read port, a sticky write-address error monitor, and a saturating store counter.

Parameters:
ADDR_W, 8, word-index width; DEPTH = 2^ADDR_W words (default 256 words = 1 KiB)
BASE_ADDR, 32'h0000_0000, byte address of word 0; must be aligned to DEPTH*4

Ports:
clk  input  1  clock; all state updates on rising edge
reset  input  1  asynchronous, active-high reset
dm_addr  input  32  byte address from MEM stage; driven every cycle, including non-memory instructions
dm_wen  input  4  byte-lane write enables; lane i covers bits [8i+7:8i]
dm_wdata  input  32  write data, already lane-aligned by the MEM stage
dm_rdata  output  32  registered read data for the address presented on the previous edge
test_addr  input  ADDR_W  display-port word index
test_data  output  32  registered word at test_addr
addr_err  output  1  sticky flag: a write was attempted outside the RAM window
err_addr  output  32  dm_addr of the first out-of-range write
store_cnt  output  16  saturating count of accepted writes

Behaviour:
- Address decode:
  - off = dm_addr - BASE_ADDR.
  - in_range = (off[31:ADDR_W+2] == 0).
  - idx = off[ADDR_W+1:2]. dm_addr[1:0] is ignored for indexing; lane selection comes only from dm_wen.
- Reset (async, active-high): dm_rdata=0, test_data=0, addr_err=0, err_addr=0, store_cnt=0, all immediately.
  - RAM contents are NOT cleared by reset.
  - While reset is high, no RAM writes occur.
  - In simulation the RAM is initialised to all zeros at time 0.
- Write, at posedge, when reset=0, in_range=1 and dm_wen!=0:
  - For each lane i with dm_wen[i]=1, mem[idx][8i+7:8i] <= dm_wdata[8i+7:8i]. Other lanes are unchanged.
  - Any dm_wen pattern is accepted (0001/0010/0100/1000/1111 from SB/SW; others written as given).
  - store_cnt increments by 1 and saturates at 16'hFFFF.
- Read, every posedge when reset=0:
  - dm_rdata <= in_range ? mem[idx] : 32'h0.
  - Latency is exactly 1 cycle. No read enable: the port reads every cycle.
  - Read-first: if a write hits the same word on the same edge, dm_rdata takes the pre-write value; the new value is visible on the following edge.
  - An out-of-range read returns 0 and raises no error, because the MEM stage presents ALU results as addresses continuously.
- Out-of-range write (in_range=0, dm_wen!=0):
  - RAM is unchanged and store_cnt is unchanged.
  - At that edge addr_err <= 1. If addr_err was 0 before the edge, err_addr <= dm_addr.
  - Later bad writes leave err_addr alone. Only reset clears addr_err and err_addr.
- Test port: test_data <= mem[test_addr] every posedge. It is read-first, independent of the data port, and has no conflicts.
- Simultaneous events:
  - A data-port write and a test-port read of the same word on the same edge: test_data gets the old value.
  - Counter saturation and an error can coexist.
- No handshake or stall output. The responder always completes a write in 1 cycle and a read in 1 cycle. This matches the MEM stage's fixed timing: a load completes one cycle after MEM_valid; other instructions complete in the same cycle.

Test Plan:
1. Reset, then dm_addr=0x10, dm_wen=1111, dm_wdata=0x12345678 for one edge; then dm_wen=0000, same address -> dm_rdata=0x12345678 one edge later; store_cnt=1.
2. dm_addr=0x12, dm_wen=0100, dm_wdata=0x00AB0000 -> word 0x10 reads 0x12AB5678; store_cnt=2.
3. Collision: dm_addr=0x20, dm_wen=1111, dm_wdata=0xDEADBEEF -> dm_rdata=0x00000000 after that edge and 0xDEADBEEF after the next edge, address held, wen=0.
4. Out-of-range:
   - Write at 0x400 (DEPTH=256) -> addr_err=1, err_addr=0x400, store_cnt unchanged, RAM unchanged.
   - Write at 0x800 -> err_addr stays 0x400.
   - Read at 0x400 -> dm_rdata=0 with no change to the error flags.
5. Assert reset between edges -> dm_rdata, test_data, addr_err, err_addr and store_cnt go to 0 before the next edge. A write presented while reset is high is dropped. After release, reading 0x10 returns 0x12AB5678.
6. test_addr=4 (word 0x10) concurrent with a data-port write of 0xCAFEF00D to 0x10 -> test_data=0x12AB5678, then 0xCAFEF00D on the next edge.

Source files
------------

// File: rtl/data_ram_resp.sv
// Data-memory responder for the MEM-stage data bus.
// Byte-lane writes, 1-cycle registered reads, debug port, error and store monitors.
module data_ram_resp #(
    parameter int unsigned ADDR_W    = 8,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [31:0]       dm_addr,
    input  logic [3:0]        dm_wen,
    input  logic [31:0]       dm_wdata,
    output logic [31:0]       dm_rdata,
    input  logic [ADDR_W-1:0] test_addr,
    output logic [31:0]       test_data,
    output logic              addr_err,
    output logic [31:0]       err_addr,
    output logic [15:0]       store_cnt
);

    localparam int unsigned DEPTH = 1 << ADDR_W;

    // Contents survive reset; zero start only matters for simulation.
    logic [31:0] mem [DEPTH] = '{default: 32'h0};

    logic [31:0]       off;
    logic              in_range;
    logic [ADDR_W-1:0] idx;
    logic              any_wen;
    logic              wr_ok;
    logic              wr_bad;

    always_comb begin
        off      = dm_addr - BASE_ADDR;
        in_range = ((off >> (ADDR_W + 2)) == 32'd0);
        idx      = off[ADDR_W+1:2];
        any_wen  = |dm_wen;
        wr_ok    = in_range && any_wen;
        wr_bad   = !in_range && any_wen;
    end

    always_ff @(posedge clk) begin
        if (!reset && wr_ok) begin
            for (int i = 0; i < 4; i++) begin
                if (dm_wen[i]) begin
                    mem[idx][8*i +: 8] <= dm_wdata[8*i +: 8];
                end
            end
        end
    end

    // Both read ports sample the pre-write word on a same-edge collision.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dm_rdata  <= 32'h0;
            test_data <= 32'h0;
        end else begin
            dm_rdata  <= in_range ? mem[idx] : 32'h0;
            test_data <= mem[test_addr];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            addr_err  <= 1'b0;
            err_addr  <= 32'h0;
            store_cnt <= 16'h0;
        end else begin
            if (wr_ok && store_cnt != 16'hFFFF) begin
                store_cnt <= store_cnt + 16'd1;
            end
            if (wr_bad) begin
                addr_err <= 1'b1;
                if (!addr_err) begin
                    err_addr <= dm_addr;
                end
            end
        end
    end

endmodule

// File: tb/tb_data_ram_resp.sv
// Directed bench for data_ram_resp.
// Hand-computed expectations for writes, lanes, collisions, errors and reset.
module tb_data_ram_resp;

    logic        clk;
    logic        reset;
    logic [31:0] dm_addr;
    logic [3:0]  dm_wen;
    logic [31:0] dm_wdata;
    logic [31:0] dm_rdata;
    logic [7:0]  test_addr;
    logic [31:0] test_data;
    logic        addr_err;
    logic [31:0] err_addr;
    logic [15:0] store_cnt;

    int n_tests;
    int n_fail;

    data_ram_resp #(
        .ADDR_W   (8),
        .BASE_ADDR(32'h0000_0000)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .dm_addr  (dm_addr),
        .dm_wen   (dm_wen),
        .dm_wdata (dm_wdata),
        .dm_rdata (dm_rdata),
        .test_addr(test_addr),
        .test_data(test_data),
        .addr_err (addr_err),
        .err_addr (err_addr),
        .store_cnt(store_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [31:0] a, input logic [3:0] w,
                         input logic [31:0] d);
        dm_addr  = a;
        dm_wen   = w;
        dm_wdata = d;
    endtask

    initial begin
        n_tests   = 0;
        n_fail    = 0;
        reset     = 1'b1;
        test_addr = 8'd0;
        drive(32'h0, 4'h0, 32'h0);
        #2;
        check("rst_rdata", dm_rdata, 32'h0);
        check("rst_tdata", test_data, 32'h0);
        check("rst_err", {31'h0, addr_err}, 32'h0);
        check("rst_eaddr", err_addr, 32'h0);
        check("rst_cnt", {16'h0, store_cnt}, 32'h0);
        tick();
        reset = 1'b0;

        // full-word store then load
        drive(32'h10, 4'hF, 32'h1234_5678);
        tick();
        drive(32'h10, 4'h0, 32'h0);
        tick();
        check("sw_load", dm_rdata, 32'h1234_5678);
        check("sw_cnt", {16'h0, store_cnt}, 32'd1);

        // byte store into lane 2
        drive(32'h12, 4'h4, 32'h00AB_0000);
        tick();
        drive(32'h10, 4'h0, 32'h0);
        tick();
        check("sb_load", dm_rdata, 32'h12AB_5678);
        check("sb_cnt", {16'h0, store_cnt}, 32'd2);

        // read-first collision
        drive(32'h20, 4'hF, 32'hDEAD_BEEF);
        tick();
        check("coll_old", dm_rdata, 32'h0);
        drive(32'h20, 4'h0, 32'h0);
        tick();
        check("coll_new", dm_rdata, 32'hDEAD_BEEF);

        // lane 0 store
        drive(32'h20, 4'h1, 32'h0000_00AA);
        tick();
        drive(32'h20, 4'h0, 32'h0);
        tick();
        check("sb0_load", dm_rdata, 32'hDEAD_BEAA);
        check("sb0_cnt", {16'h0, store_cnt}, 32'd4);

        // out-of-range writes
        drive(32'h400, 4'hF, 32'h1111_1111);
        tick();
        check("oor_err", {31'h0, addr_err}, 32'h1);
        check("oor_eaddr", err_addr, 32'h400);
        check("oor_cnt", {16'h0, store_cnt}, 32'd4);
        drive(32'h800, 4'hF, 32'h2222_2222);
        tick();
        check("oor2_eaddr", err_addr, 32'h400);
        check("oor2_err", {31'h0, addr_err}, 32'h1);
        drive(32'h400, 4'h0, 32'h0);
        tick();
        check("oor_rd", dm_rdata, 32'h0);
        check("oor_rd_err", {31'h0, addr_err}, 32'h1);
        check("oor_rd_eaddr", err_addr, 32'h400);
        drive(32'h0, 4'h0, 32'h0);
        tick();
        check("oor_word0", dm_rdata, 32'h0);
        check("oor_tword0", test_data, 32'h0);

        // async reset between edges, write dropped during reset
        reset = 1'b1;
        #1;
        check("arst_rdata", dm_rdata, 32'h0);
        check("arst_err", {31'h0, addr_err}, 32'h0);
        check("arst_eaddr", err_addr, 32'h0);
        check("arst_cnt", {16'h0, store_cnt}, 32'd0);
        drive(32'h10, 4'hF, 32'hFFFF_FFFF);
        tick();
        reset = 1'b0;
        drive(32'h10, 4'h0, 32'h0);
        tick();
        check("post_rst_rd", dm_rdata, 32'h12AB_5678);
        check("post_rst_cnt", {16'h0, store_cnt}, 32'd0);

        // test port vs same-word data write
        test_addr = 8'd4;
        drive(32'h10, 4'hF, 32'hCAFE_F00D);
        tick();
        check("tp_old", test_data, 32'h12AB_5678);
        drive(32'h10, 4'h0, 32'h0);
        tick();
        check("tp_new", test_data, 32'hCAFE_F00D);
        check("tp_cnt", {16'h0, store_cnt}, 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
